// File: rtl/int_sched.sv
// Machine-level interrupt scheduler: mtime/mtimecmp/msip registers and a REQ/ACK/MRET arbiter.
// Define INT_SCHED_EXT_EN to add the synchronized external interrupt source (MEI).
module int_sched #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        reg_wr_en_i,
    input  logic [4:0]  reg_addr_i,
    input  logic [31:0] reg_wdata_i,
    output logic [31:0] reg_rdata_o,
    input  logic        glob_ie_i,
    input  logic [2:0]  mie_i,
`ifdef INT_SCHED_EXT_EN
    input  logic        ext_int_i,
`endif
    input  logic        trap_ack_i,
    input  logic        mret_i,
    output logic        int_req_o,
    output logic [31:0] int_cause_o,
    output logic        int_timer_o,
    output logic [2:0]  mip_o
);

    localparam logic [15:0] PRESC_TC = 16'(TICK_DIV - 1);
    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE
    } state_e;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic [15:0] presc_q, presc_d;
    logic        meip;
    logic        mtip;
    logic [2:0]  elig;
    logic [2:0]  win_src;
    logic [31:0] win_cause;

    state_e      state_q;
    logic        int_req_q;
    logic [31:0] cause_q;
    logic [2:0]  src_q;

    logic        unused_addr;
    assign unused_addr = ^reg_addr_i[1:0];

`ifdef INT_SCHED_EXT_EN
    logic [1:0] ext_sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ext_sync_q <= 2'b00;
        end else begin
            ext_sync_q <= {ext_sync_q[0], ext_int_i};
        end
    end

    assign meip = ext_sync_q[1];
`else
    assign meip = 1'b0;
`endif

    // A write to either mtime half suppresses the tick and restarts the prescaler.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        presc_d    = presc_q;
        if (presc_q == PRESC_TC) begin
            presc_d = 16'd0;
            mtime_d = mtime_q + 64'd1;
        end else begin
            presc_d = presc_q + 16'd1;
        end
        if (reg_wr_en_i) begin
            case (reg_addr_i[4:2])
                3'd0: msip_d = reg_wdata_i[0];
                3'd1: mtimecmp_d[31:0] = reg_wdata_i;
                3'd2: mtimecmp_d[63:32] = reg_wdata_i;
                3'd3: begin
                    mtime_d = {mtime_q[63:32], reg_wdata_i};
                    presc_d = 16'd0;
                end
                3'd4: begin
                    mtime_d = {reg_wdata_i, mtime_q[31:0]};
                    presc_d = 16'd0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            presc_q    <= 16'd0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            presc_q    <= presc_d;
        end
    end

    always_comb begin
        case (reg_addr_i[4:2])
            3'd0:    reg_rdata_o = {31'd0, msip_q};
            3'd1:    reg_rdata_o = mtimecmp_q[31:0];
            3'd2:    reg_rdata_o = mtimecmp_q[63:32];
            3'd3:    reg_rdata_o = mtime_q[31:0];
            3'd4:    reg_rdata_o = mtime_q[63:32];
            default: reg_rdata_o = 32'd0;
        endcase
    end

    assign mtip  = (mtime_q >= mtimecmp_q);
    assign mip_o = {meip, mtip, msip_q};
    assign elig  = glob_ie_i ? (mip_o & mie_i) : 3'b000;

    // Bit order is {MEI, MTI, MSI}; MSI outranks MTI.
    always_comb begin
        win_src   = 3'b010;
        win_cause = CAUSE_MTI;
        if (elig[2]) begin
            win_src   = 3'b100;
            win_cause = CAUSE_MEI;
        end else if (elig[0]) begin
            win_src   = 3'b001;
            win_cause = CAUSE_MSI;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            int_req_q <= 1'b0;
            cause_q   <= 32'd0;
            src_q     <= 3'b000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (elig != 3'b000) begin
                        state_q   <= S_REQ;
                        int_req_q <= 1'b1;
                        cause_q   <= win_cause;
                        src_q     <= win_src;
                    end
                end
                S_REQ: begin
                    if (trap_ack_i) begin
                        state_q   <= S_SERVICE;
                        int_req_q <= 1'b0;
                    end else if ((elig & src_q) == 3'b000) begin
                        state_q   <= S_IDLE;
                        int_req_q <= 1'b0;
                    end
                end
                S_SERVICE: begin
                    int_req_q <= 1'b0;
                    if (mret_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    int_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign int_req_o   = int_req_q;
    assign int_cause_o = cause_q;
    assign int_timer_o = int_req_q && (cause_q == CAUSE_MTI);

endmodule
